// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and FSM state type for the ctrl_tx register-write UART transmitter.
// Frame length grows to FRAME_LEN_CSUM when CTRL_TX_CHECKSUM_EN is defined.
package ctrl_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int FRAME_LEN = 3;
    localparam int FRAME_LEN_CSUM = 4;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with a DIV-cycle baud down-counter.
// take pulses when a byte is accepted; a pending byte is taken at the end of a stop bit without a gap.
module uart_tx_byte
    import ctrl_pkg::*;
#(
    parameter int DIV = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       take,
    output logic       tx,
    output logic       busy
);
    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    tx_state_t state, next_state;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0] bit_idx, bit_nxt;
    logic [7:0] shreg, sh_nxt;
    logic tx_nxt;
    logic done;

    assign done = cnt == '0;
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= next_state;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= sh_nxt;
            tx      <= tx_nxt;
        end
    end

    always_comb begin
        next_state = state;
        cnt_nxt    = done ? RELOAD : cnt - 1'b1;
        bit_nxt    = bit_idx;
        sh_nxt     = shreg;
        tx_nxt     = tx;
        take       = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (valid) begin
                    take       = 1'b1;
                    next_state = START;
                    cnt_nxt    = RELOAD;
                    sh_nxt     = data;
                    tx_nxt     = 1'b0;
                end
            end
            START: begin
                if (done) begin
                    next_state = DATA;
                    bit_nxt    = '0;
                    tx_nxt     = shreg[0];
                end
            end
            DATA: begin
                if (done) begin
                    if (bit_idx == 3'd7) begin
                        next_state = STOP;
                        tx_nxt     = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                        sh_nxt  = shreg >> 1;
                        tx_nxt  = shreg[1];
                    end
                end
            end
            STOP: begin
                if (done) begin
                    if (valid) begin
                        take       = 1'b1;
                        next_state = START;
                        sh_nxt     = data;
                        tx_nxt     = 1'b0;
                    end else begin
                        next_state = IDLE;
                        cnt_nxt    = '0;
                    end
                end
            end
        endcase
    end
endmodule

// File: rtl/ctrl_tx.sv
// ctrl_tx: queues {addr,data} register writes and sends each as a sync/addr/data UART frame.
// Define CTRL_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module ctrl_tx
    import ctrl_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_wr,
    input  logic [3:0] I_addr,
    input  logic [7:0] I_data,
    output logic       O_full,
    output logic       O_busy,
    output logic       O_drop,
    output logic       O_tx
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef CTRL_TX_CHECKSUM_EN
    localparam int FLEN = FRAME_LEN_CSUM;
`else
    localparam int FLEN = FRAME_LEN;
`endif

    logic [11:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic [11:0] cur;
    logic [1:0] idx;
    logic [7:0] tx_byte;
    logic empty, push, pop, valid, take, ser_busy;

    assign empty  = wptr == rptr;
    assign O_full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign O_busy = ser_busy || !empty;
    assign push   = I_wr && !O_full;
    assign valid  = idx != 2'd0 || !empty;
    assign pop    = take && idx == 2'd0;

`ifdef CTRL_TX_CHECKSUM_EN
    assign tx_byte = idx == 2'd0 ? SYNC_BYTE :
                     idx == 2'd1 ? {4'h0, cur[11:8]} :
                     idx == 2'd2 ? cur[7:0] :
                     SYNC_BYTE ^ {4'h0, cur[11:8]} ^ cur[7:0];
`else
    assign tx_byte = idx == 2'd0 ? SYNC_BYTE :
                     idx == 2'd1 ? {4'h0, cur[11:8]} : cur[7:0];
`endif

    always_ff @(posedge I_clk) begin
        if (push) mem[wptr[AW-1:0]] <= {I_addr, I_data};
    end

    // the head entry is latched at the sync byte so addr/data stay stable for the rest of the frame
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            cur    <= '0;
            idx    <= '0;
            O_drop <= 1'b0;
        end else begin
            O_drop <= I_wr && O_full;
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr <= rptr + 1'b1;
                cur  <= mem[rptr[AW-1:0]];
            end
            if (take) idx <= idx == 2'(FLEN - 1) ? 2'd0 : idx + 1'b1;
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_ser (
        .clk  (I_clk),
        .rst_n(I_rst_n),
        .valid(valid),
        .data (tx_byte),
        .take (take),
        .tx   (O_tx),
        .busy (ser_busy)
    );
endmodule

// File: tb/tb_ctrl_tx.sv
// tb_ctrl_tx: cycle-level frame-timeline reference model plus UART decoder for ctrl_tx.
// Follows CTRL_TX_CHECKSUM_EN to expect three- or four-byte frames.
module tb_ctrl_tx;
    localparam int DIV = 10;
    localparam int DIV2 = 234;
    localparam int DEPTH = 4;
`ifdef CTRL_TX_CHECKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif
    localparam int F = FLEN * 10 * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rst2_n = 1'b1;
    logic I_wr = 1'b0, wr2 = 1'b0;
    logic [3:0] I_addr = '0, addr2 = '0;
    logic [7:0] I_data = '0, data2 = '0;
    logic O_full, O_busy, O_drop, O_tx;
    logic full2, busy2, drop2, tx2;

    always #5 clk = ~clk;

    ctrl_tx #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_wr(I_wr), .I_addr(I_addr), .I_data(I_data),
        .O_full(O_full), .O_busy(O_busy), .O_drop(O_drop), .O_tx(O_tx)
    );

    ctrl_tx dut2 (
        .I_clk(clk), .I_rst_n(rst2_n), .I_wr(wr2), .I_addr(addr2), .I_data(data2),
        .O_full(full2), .O_busy(busy2), .O_drop(drop2), .O_tx(tx2)
    );

    function automatic logic [7:0] fbyte(logic [11:0] f, int k);
        logic [7:0] b [4];
        b[0] = 8'hA5;
        b[1] = {4'h0, f[11:8]};
        b[2] = f[7:0];
        b[3] = b[0] ^ b[1] ^ b[2];
        return b[k];
    endfunction

    function automatic logic fbit(logic [11:0] f, int n);
        logic [7:0] b;
        int j;
        b = fbyte(f, n / 10);
        j = n % 10;
        return j == 0 ? 1'b0 : j == 9 ? 1'b1 : b[j-1];
    endfunction

    // reference model: a frame occupies exactly F cycles from the cycle after its pop
    logic [11:0] mq[$];
    logic [7:0] exp_bytes[$];
    logic [11:0] cur_frame = '0;
    int remain = 0;
    logic exp_drop = 1'b0;
    logic m_pop, m_full;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            remain = 0;
            exp_drop = 1'b0;
        end else begin
            m_pop = mq.size() > 0 && remain <= 1;
            m_full = mq.size() == DEPTH;
            exp_drop = I_wr && m_full;
            if (m_pop) begin
                cur_frame = mq.pop_front();
                remain = F;
                for (int k = 0; k < FLEN; k++) exp_bytes.push_back(fbyte(cur_frame, k));
            end else if (remain > 0) remain = remain - 1;
            if (I_wr && !m_full) mq.push_back({I_addr, I_data});
        end
    end

    function automatic logic exp_tx();
        return remain == 0 ? 1'b1 : fbit(cur_frame, (F - remain) / DIV);
    endfunction

    // UART receiver sampling mid-bit
    logic [7:0] rx_q[$];
    logic rx_stop[$];
    logic [7:0] rb;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && O_tx === 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    rb[i] = O_tx;
                end
                repeat (DIV) @(negedge clk);
                rx_q.push_back(rb);
                rx_stop.push_back(O_tx);
            end
        end
    end

    int pass_cnt = 0;
    int tot = 0;
    logic chk = 1'b0;
    int rx_base = 0;
    int ex_base = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk && rst_n) begin
            check("tx", O_tx, exp_tx());
            check("busy", O_busy, remain > 0 || mq.size() > 0);
            check("full", O_full, mq.size() == DEPTH);
            check("drop", O_drop, exp_drop);
        end
    endtask

    task automatic push(logic [3:0] a, logic [7:0] d);
        I_wr = 1'b1;
        I_addr = a;
        I_data = d;
        tick();
        I_wr = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((remain != 0 || mq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", n < budget, 1);
    endtask

    task automatic cmp_stream(string name);
        int ne = exp_bytes.size() - ex_base;
        check({name, "_count"}, rx_q.size() - rx_base, ne);
        for (int i = 0; i < ne && rx_base + i < rx_q.size(); i++) begin
            check(name, rx_q[rx_base+i], exp_bytes[ex_base+i]);
            check({name, "_stop"}, rx_stop[rx_base+i], 1);
        end
        rx_base = rx_q.size();
        ex_base = exp_bytes.size();
    endtask

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] cs;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int n;
        logic ok;
        vecs[0] = '{4'h3, 8'h5A, 8'h03, 8'h5A, 8'hFC};
        vecs[1] = '{4'hF, 8'hFF, 8'h0F, 8'hFF, 8'h55};
        vecs[2] = '{4'h0, 8'h00, 8'h00, 8'h00, 8'hA5};
        vecs[3] = '{4'h8, 8'h81, 8'h08, 8'h81, 8'h2C};
        vecs[4] = '{4'hC, 8'h3C, 8'h0C, 8'h3C, 8'h95};

        #1 rst_n = 1'b0;
        rst2_n = 1'b0;
        repeat (3) tick();
        check("rst_tx", O_tx, 1);
        check("rst_busy", O_busy, 0);
        check("rst_full", O_full, 0);
        check("rst_drop", O_drop, 0);
        rst_n = 1'b1;
        tick();
        chk = 1'b1;
        tick();

        foreach (vecs[v]) begin
            rx_base = rx_q.size();
            push(vecs[v].a, vecs[v].d);
            check("lat_n1", O_tx, 1);
            tick();
            check("lat_n2", O_tx, 0);
            wait_idle(2 * F);
            check("vec_count", rx_q.size() - rx_base, FLEN);
            if (rx_q.size() - rx_base >= FLEN) begin
                check("vec_sync", rx_q[rx_base], 8'hA5);
                check("vec_addr", rx_q[rx_base+1], vecs[v].b1);
                check("vec_data", rx_q[rx_base+2], vecs[v].b2);
                if (FLEN == 4) check("vec_csum", rx_q[rx_base+FLEN-1], vecs[v].cs);
            end
            rx_base = rx_q.size();
            ex_base = exp_bytes.size();
            repeat (3) tick();
        end

        push(4'h1, 8'h11);
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            push(4'(4 + i), 8'(8'h20 + i));
            if (i == 3) check("full_after_4th", O_full, 1);
        end
        check("drop_5th", O_drop, 1);
        tick();
        check("drop_one_cycle", O_drop, 0);
        n = 0;
        while (remain != 1 && n < 2 * F) begin
            tick();
            n++;
        end
        check("pop_wait", n < 2 * F, 1);
        push(4'hE, 8'hEE);
        check("drop_at_pop", O_drop, 1);
        check("full_after_pop", O_full, 0);
        wait_idle(6 * F);
        cmp_stream("burst");

        push(4'h2, 8'h22);
        push(4'h3, 8'h33);
        push(4'h5, 8'h55);
        n = 0;
        while (!(remain > 0 && F - remain == 13 * DIV + 3) && n < 2 * F) begin
            tick();
            n++;
        end
        check("rst_point_wait", n < 2 * F, 1);
        chk = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx", O_tx, 1);
        check("midrst_busy", O_busy, 0);
        check("midrst_full", O_full, 0);
        check("midrst_drop", O_drop, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        chk = 1'b1;
        repeat (100 * DIV) tick();
        check("post_rst_tx", O_tx, 1);
        check("post_rst_busy", O_busy, 0);
        rx_base = rx_q.size();
        ex_base = exp_bytes.size();

        for (int i = 0; i < 400; i++) begin
            I_wr = $urandom_range(0, 3) == 0;
            I_addr = 4'($urandom);
            I_data = 8'($urandom);
            tick();
        end
        I_wr = 1'b0;
        wait_idle(6 * F);
        cmp_stream("rand");

        rst2_n = 1'b1;
        tick();
        check("d2_idle_tx", tx2, 1);
        check("d2_idle_busy", busy2, 0);
        wr2 = 1'b1;
        tick();
        wr2 = 1'b0;
        check("d2_lat_n1", tx2, 1);
        for (int k = 0; k < FLEN * 10; k++) begin
            ok = 1'b1;
            for (int s = 0; s < DIV2; s++) begin
                tick();
                if (tx2 !== fbit(12'h000, k)) ok = 1'b0;
            end
            check($sformatf("d2_bit%0d", k), ok, 1);
        end
        tick();
        check("d2_end_busy", busy2, 0);
        check("d2_end_tx", tx2, 1);
        check("d2_full", full2, 0);
        check("d2_drop", drop2, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end
endmodule

// File: doc/ctrl_tx.md
CTRL_TX -- requirements
Module: ctrl_tx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 27000000, meaning the I_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the UART bit rate.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued frames (power of two, at least 2).
REQ-004 I_clk  input  1  sole clock; all logic is on its rising edge.
REQ-005 I_rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 I_wr  input  1  single-cycle push request for one frame.
REQ-007 I_addr  input  4  register address sampled with I_wr.
REQ-008 I_data  input  8  register data sampled with I_wr.
REQ-009 O_full  output  1  high when the FIFO holds FIFO_DEPTH frames.
REQ-010 O_busy  output  1  high while a frame is being serialized or the FIFO is non-empty.
REQ-011 O_drop  output  1  one-cycle pulse when a push is rejected.
REQ-012 O_tx  output  1  UART serial line, idle high.

Function
REQ-013 The bit period SHALL be DIV = CLK_HZ/BAUD I_clk cycles (integer truncation, 234 at defaults), counted by a down-counter reloaded at each bit boundary.
REQ-014 A push with I_wr=1 and O_full=0 SHALL write {I_addr,I_data} into the FIFO; with O_full=1 the push SHALL be discarded and O_drop pulsed on the next cycle, even if a pop occurs in the same cycle.
REQ-015 Each frame SHALL be sent as bytes 0xA5, {4'h0,addr}, data, in that order, each framed 8N1, LSB first, with no idle gap between bytes or between back-to-back frames.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START when the FIFO is non-empty (pop in the same cycle); START->DATA after DIV cycles; DATA->STOP after 8 bit periods; STOP->START if bytes remain in the frame or the FIFO is non-empty, else STOP->IDLE, after DIV cycles.
REQ-017 Latency: a push at cycle N into an empty, idle block SHALL drive O_tx low (start bit) from cycle N+2.
REQ-018 O_tx SHALL be registered and glitch-free; O_tx SHALL be 1 in IDLE and STOP, 0 in START, and the current data bit in DATA.
REQ-019 FIFO read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH; full when the pointers differ only in the MSB, empty when they are equal.
REQ-020 A simultaneous push and pop with the FIFO neither full nor empty SHALL leave the occupancy unchanged.

Reset
REQ-021 While I_rst_n=0: O_tx=1, O_full=0, O_busy=0, O_drop=0, FSM=IDLE, FIFO empty, counters zero.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately and discard all queued frames; after release the line SHALL stay idle until a new push.

Configuration
REQ-023 With macro CTRL_TX_CHECKSUM_EN defined, each frame SHALL carry a fourth byte equal to 0xA5 ^ {4'h0,addr} ^ data, sent after the data byte.
REQ-024 Without CTRL_TX_CHECKSUM_EN, frames SHALL be exactly three bytes and no checksum logic SHALL be synthesized.

Structure
REQ-025 Package ctrl_pkg SHALL hold the sync byte constant 0xA5, the frame-length constants (3 and 4), and the FSM state enumeration.
REQ-026 Byte serialization (start/data/stop, baud counter) SHALL be the sub-module uart_tx_byte; ctrl_tx SHALL contain the FIFO and frame sequencing.

Verification
REQ-027 CLK_HZ=1000, BAUD=100 (DIV=10); push addr=3, data=0x5A -> O_tx low from cycle N+2; decoded bytes 0xA5, 0x03, 0x5A; 30 bit periods total; O_busy falls after the last stop bit.
REQ-028 Five pushes on consecutive cycles with FIFO_DEPTH=4 -> first four accepted; O_full high after the 4th; fifth rejected with a one-cycle O_drop; four frames sent back-to-back in order.
REQ-029 Push while full, in the same cycle as the first-frame pop -> push dropped; O_drop pulses; occupancy falls to 3.
REQ-030 Assert I_rst_n=0 mid-DATA of the second byte with 2 frames queued -> O_tx=1 immediately; after release, no traffic for 100 bit periods; O_busy=0.
REQ-031 With CTRL_TX_CHECKSUM_EN, push addr=0xF, data=0xFF -> bytes 0xA5, 0x0F, 0xFF, 0x55.
REQ-032 Defaults (DIV=234); push addr=0, data=0x00 -> every bit lasts exactly 234 cycles; stop bits are high.
